// File: rtl/char_plotter.sv
// Walks one 8x8 glyph from a synchronous font ROM and issues per-pixel writes.
// Define CHAR_PLOTTER_TRANSPARENT_BG_EN to leave glyph 0-bits unplotted.
module char_plotter #(
    parameter int          COLS      = 20,
    parameter int          ROWS      = 15,
    parameter logic [2:0]  BG_COLOUR = 3'b000
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       char_valid,
    output logic       char_ready,
    input  logic [6:0] char_code,
    input  logic [4:0] char_col,
    input  logic [3:0] char_row,
    input  logic [2:0] char_colour,
    output logic [9:0] font_addr,
    input  logic [7:0] font_data,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       done
);

    typedef enum logic [2:0] {IDLE, FETCH, WAIT, DRAW, DONE} state_t;

    localparam logic [4:0] COL_LIMIT = 5'(COLS);
    localparam logic [3:0] ROW_LIMIT = 4'(ROWS);

    state_t     state;
    state_t     next_state;
    logic [5:0] idx;
    logic [6:0] req_code;
    logic [4:0] req_col;
    logic [3:0] req_row;
    logic [2:0] req_colour;
    logic [7:0] row_bits;
    logic       pixel;

    // Request fields are captured only on the IDLE handshake, so later
    // char_valid activity cannot disturb a character in progress.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state      <= IDLE;
            idx        <= 6'd0;
            req_code   <= 7'd0;
            req_col    <= 5'd0;
            req_row    <= 4'd0;
            req_colour <= 3'd0;
            row_bits   <= 8'd0;
        end else begin
            state <= next_state;
            if (state == IDLE && char_valid) begin
                req_code   <= char_code;
                req_col    <= char_col;
                req_row    <= char_row;
                req_colour <= char_colour;
            end
            if (state == WAIT)
                row_bits <= font_data;
            if (state == DRAW)
                idx <= idx + 6'd1;
        end
    end

    assign font_addr = {req_code, idx[5:3]};
    assign pixel     = row_bits[~idx[2:0]];

    always_comb begin
        next_state = state;
        char_ready = 1'b0;
        plot       = 1'b0;
        done       = 1'b0;
        x          = 8'd0;
        y          = 7'd0;
        colour     = 3'd0;
        case (state)
            IDLE: begin
                char_ready = 1'b1;
                if (char_valid) begin
                    if (char_col >= COL_LIMIT || char_row >= ROW_LIMIT)
                        next_state = DONE;
                    else
                        next_state = FETCH;
                end
            end
            FETCH: next_state = WAIT;
            WAIT:  next_state = DRAW;
            DRAW: begin
                // Cell origin is col*8,row*8, so concatenation gives the pixel address.
                x = {req_col, idx[2:0]};
                y = {req_row, idx[5:3]};
                if (pixel) begin
                    plot   = 1'b1;
                    colour = req_colour;
                end else begin
`ifdef CHAR_PLOTTER_TRANSPARENT_BG_EN
                    plot   = 1'b0;
`else
                    plot   = 1'b1;
                    colour = BG_COLOUR;
`endif
                end
                if (idx[2:0] == 3'd7)
                    next_state = (idx[5:3] == 3'd7) ? DONE : FETCH;
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_char_plotter.sv
// Directed self-checking bench for char_plotter with a behavioural synchronous font ROM.
module tb_char_plotter;

    localparam logic [2:0] BG = 3'b000;

    logic       clock;
    logic       resetn;
    logic       char_valid;
    logic       char_ready;
    logic [6:0] char_code;
    logic [4:0] char_col;
    logic [3:0] char_row;
    logic [2:0] char_colour;
    logic [9:0] font_addr;
    logic [7:0] font_data;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       done;

    int checks = 0;
    int errors = 0;
    int rom_mode = 0;

    char_plotter dut (
        .clock      (clock),
        .resetn     (resetn),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .char_code  (char_code),
        .char_col   (char_col),
        .char_row   (char_row),
        .char_colour(char_colour),
        .font_addr  (font_addr),
        .font_data  (font_data),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .plot       (plot),
        .done       (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [7:0] rom_byte(input logic [9:0] a);
        if (rom_mode == 0)
            return 8'h18;
        return a[7:0] ^ 8'h5A ^ {a[9:8], 6'b0};
    endfunction

    // Font ROM: one-cycle read latency.
    always @(posedge clock) font_data <= rom_byte(font_addr);

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Full-character check against a cycle-indexed timing model; cycle k follows acceptance edge E.
    task automatic check_char(input logic [6:0] code, input logic [4:0] col, input logic [3:0] row,
                              input logic [2:0] fg, input bit hold, input bit pulse, input string tag);
        int waited;
        int r, p, b, exp_x, exp_y;
        logic [7:0] bits;
        logic exp_plot, exp_done, exp_ready;
        logic [2:0] exp_colour;
        bit in_draw;
        char_code   = code;
        char_col    = col;
        char_row    = row;
        char_colour = fg;
        char_valid  = 1'b1;
        waited = 0;
        while (char_ready !== 1'b1 && waited < 200) begin
            @(negedge clock);
            waited++;
        end
        checks++;
        if (waited != 0) begin
            errors++;
            $display("[TB] FAIL %s accept_wait: waited %0d cycles, required 0", tag, waited);
        end
        if (char_ready !== 1'b1) return;
        @(posedge clock);
        for (int k = 1; k <= 82; k++) begin
            @(negedge clock);
            if (k == 1 && !hold) char_valid = 1'b0;
            if (pulse && k == 25) begin
                char_valid = 1'b1; char_code = 7'h55; char_col = 5'd1; char_row = 4'd1; char_colour = 3'd0;
            end
            if (pulse && k == 26) char_valid = 1'b0;
            r = (k - 1) / 10;
            p = (k - 1) % 10;
            exp_plot = 1'b0; exp_done = 1'b0; exp_ready = 1'b0; exp_colour = 3'd0;
            exp_x = 0; exp_y = 0; in_draw = 0;
            if (k <= 80 && p >= 2) begin
                in_draw = 1;
                b = p - 2;
                bits = rom_byte({code, 3'(r)});
                exp_x = col * 8 + b;
                exp_y = row * 8 + r;
`ifdef CHAR_PLOTTER_TRANSPARENT_BG_EN
                exp_plot   = bits[7 - b];
                exp_colour = fg;
`else
                exp_plot   = 1'b1;
                exp_colour = bits[7 - b] ? fg : BG;
`endif
            end
            if (k == 81) exp_done = 1'b1;
            if (k == 82) exp_ready = 1'b1;
            checks++;
            if (plot !== exp_plot) begin
                errors++;
                $display("[TB] FAIL %s plot k=%0d: got %b expected %b", tag, k, plot, exp_plot);
            end
            checks++;
            if (done !== exp_done) begin
                errors++;
                $display("[TB] FAIL %s done k=%0d: got %b expected %b", tag, k, done, exp_done);
            end
            checks++;
            if (char_ready !== exp_ready) begin
                errors++;
                $display("[TB] FAIL %s ready k=%0d: got %b expected %b", tag, k, char_ready, exp_ready);
            end
            if (in_draw) begin
                checks++;
                if (x !== 8'(exp_x) || y !== 7'(exp_y)) begin
                    errors++;
                    $display("[TB] FAIL %s xy k=%0d: got (%0d,%0d) expected (%0d,%0d)", tag, k, x, y, exp_x, exp_y);
                end
                if (exp_plot) begin
                    checks++;
                    if (colour !== exp_colour) begin
                        errors++;
                        $display("[TB] FAIL %s colour k=%0d: got %0d expected %0d", tag, k, colour, exp_colour);
                    end
                end
            end
            if (k <= 80 && p == 0) begin
                checks++;
                if (font_addr !== {code, 3'(r)}) begin
                    errors++;
                    $display("[TB] FAIL %s font_addr k=%0d: got %h expected %h", tag, k, font_addr, {code, 3'(r)});
                end
            end
        end
    endtask

    task automatic test_reset;
        resetn = 1'b0; char_valid = 1'b0; char_code = '0; char_col = '0; char_row = '0; char_colour = '0;
        repeat (3) @(negedge clock);
        resetn = 1'b1;
        repeat (5) @(negedge clock);
        checks++;
        if (char_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset ready: got %b expected 1", char_ready); end
        checks++;
        if (plot !== 1'b0) begin errors++; $display("[TB] FAIL reset plot: got %b expected 0", plot); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset done: got %b expected 0", done); end
        checks++;
        if (font_addr !== 10'd0) begin errors++; $display("[TB] FAIL reset font_addr: got %h expected 000", font_addr); end
        checks++;
        if (x !== 8'd0 || y !== 7'd0 || colour !== 3'd0) begin
            errors++;
            $display("[TB] FAIL reset xyc: got (%0d,%0d,%0d) expected (0,0,0)", x, y, colour);
        end
    endtask

    task automatic test_basic;
        rom_mode = 0;
        check_char(7'h41, 5'd0, 4'd0, 3'b111, 1'b0, 1'b0, "basic");
    endtask

    task automatic test_corner;
        rom_mode = 1;
        check_char(7'h41, 5'd19, 4'd14, 3'b011, 1'b0, 1'b0, "corner");
    endtask

    task automatic test_out_of_range(input logic [4:0] col, input logic [3:0] row, input string tag);
        char_code = 7'h41; char_col = col; char_row = row; char_colour = 3'b111; char_valid = 1'b1;
        checks++;
        if (char_ready !== 1'b1) begin errors++; $display("[TB] FAIL %s ready_pre: got %b expected 1", tag, char_ready); end
        @(posedge clock);
        @(negedge clock);
        char_valid = 1'b0;
        checks++;
        if (done !== 1'b1 || plot !== 1'b0 || char_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s cycle1: got done=%b plot=%b ready=%b expected 1 0 0", tag, done, plot, char_ready);
        end
        @(negedge clock);
        checks++;
        if (done !== 1'b0 || plot !== 1'b0 || char_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s cycle2: got done=%b plot=%b ready=%b expected 0 0 1", tag, done, plot, char_ready);
        end
    endtask

    task automatic test_reset_mid;
        rom_mode = 1;
        char_code = 7'h30; char_col = 5'd3; char_row = 4'd5; char_colour = 3'b110; char_valid = 1'b1;
        checks++;
        if (char_ready !== 1'b1) begin errors++; $display("[TB] FAIL rmid ready_pre: got %b expected 1", char_ready); end
        @(posedge clock);
        @(negedge clock);
        char_valid = 1'b0;
        repeat (43) @(negedge clock);
        checks++;
        if (y !== 7'd44) begin errors++; $display("[TB] FAIL rmid row4: got y=%0d expected 44", y); end
        resetn = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        checks++;
        if (plot !== 1'b0 || done !== 1'b0 || char_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rmid after: got plot=%b done=%b ready=%b expected 0 0 1", plot, done, char_ready);
        end
        for (int i = 0; i < 90; i++) begin
            @(negedge clock);
            checks++;
            if (plot !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("[TB] FAIL rmid quiet i=%0d: got plot=%b done=%b expected 0 0", i, plot, done);
            end
        end
        check_char(7'h30, 5'd3, 4'd5, 3'b110, 1'b0, 1'b0, "rmid_next");
    endtask

    task automatic test_back_to_back;
        rom_mode = 1;
        check_char(7'h23, 5'd5, 4'd7, 3'b010, 1'b1, 1'b0, "b2b_first");
        check_char(7'h7E, 5'd10, 4'd2, 3'b101, 1'b0, 1'b1, "b2b_second");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corner();
        test_out_of_range(5'd20, 4'd3, "oor_col");
        test_out_of_range(5'd0, 4'd15, "oor_row");
        test_out_of_range(5'd31, 4'd14, "oor_max");
        test_reset_mid();
        test_back_to_back();
        repeat (2) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/char_plotter.md
Name: char_plotter

Overview:
- Downstream consumer of the per-character 64-pixel sequencing: takes one character draw request (code, text cell, colour) and walks its 8x8 glyph pixel by pixel.
- Fetches each glyph row from an external synchronous font ROM.
- Drives the VGA adapter pixel-write interface (x, y, colour, plot) for a 160x120 framebuffer laid out as 20x15 text cells.
- Pulses done once all 64 pixels of the character have been issued.

Parameters:
- COLS, 20, text columns; valid char_col range 0..COLS-1
- ROWS, 15, text rows; valid char_row range 0..ROWS-1
- BG_COLOUR, 3'b000, colour written for glyph 0-bits (non-transparent build only)

Ports:
- clock  in  1  system clock
- resetn  in  1  synchronous active-low reset
- char_valid  in  1  request present
- char_ready  out  1  block can accept a request; high only in IDLE
- char_code  in  7  ASCII code
- char_col  in  5  text column
- char_row  in  4  text row
- char_colour  in  3  foreground colour
- font_addr  out  10  ROM address {code, glyph_row[2:0]}
- font_data  in  8  ROM row byte; valid one cycle after font_addr is presented; bit 7 = leftmost pixel
- x  out  8  pixel x
- y  out  7  pixel y
- colour  out  3  pixel colour
- plot  out  1  pixel write strobe
- done  out  1  one-cycle pulse at character completion

Behaviour:
- States: IDLE, FETCH, WAIT, DRAW, DONE.
- Reset values: state IDLE; pixel index 0; font_addr 0; x 0; y 0; colour 0; plot 0; done 0; char_ready 1 (IDLE).
- Acceptance:
  - Handshake is char_valid && char_ready at a clock edge.
  - code/col/row/colour are latched on that edge.
  - Inputs are ignored outside IDLE.
- Range check:
  - If the latched col >= COLS or row >= ROWS, go IDLE -> DONE.
  - No plot is asserted for that request; done pulses as normal.
- Pixel index: 6-bit idx, 0..63.
  - glyph_row = idx[5:3]; bit position = idx[2:0].
  - Wraps 63 -> 0 on leaving the last DRAW cycle.
- FETCH (1 cycle): font_addr = {code, idx[5:3]}.
- WAIT (1 cycle): font_data is captured into the row register at the end of the cycle.
- DRAW (8 cycles, idx[2:0] = 0..7), with outputs combinational from registered state:
  - x = col*8 + idx[2:0]
  - y = row*8 + idx[5:3]
  - pixel bit = rowreg[7 - idx[2:0]]
  - bit = 1: plot = 1, colour = char_colour.
  - bit = 0: behaviour depends on the optional feature.
  - idx increments every DRAW cycle.
  - After idx[2:0] == 7: go to FETCH if idx[5:3] != 7, else go to DONE.
- DONE (1 cycle): done = 1, char_ready = 0, plot = 0; then IDLE.
- Timing, with acceptance at edge E:
  - FETCH is cycle E+1.
  - First plot is in cycle E+3.
  - Each glyph row takes 10 cycles.
  - Last plot is in cycle E+80.
  - done is high in cycle E+81.
  - char_ready returns in cycle E+82.
  - Out-of-range request: done is high in cycle E+1.
- plot is 0 in every non-DRAW state.
- x and y never exceed 159 and 119 for accepted in-range requests.
- Reset mid-character: next cycle is IDLE; plot and done are 0; no further pixels or done pulse for the aborted character.
- Back-to-back: a new request may be accepted in the first IDLE cycle after DONE.

Optional Feature:
- Macro: CHAR_PLOTTER_TRANSPARENT_BG_EN
- Defined: glyph 0-bits give plot = 0 for that DRAW cycle (background untouched); DRAW still lasts 8 cycles per row, so timing is unchanged.
- Undefined: glyph 0-bits give plot = 1 with colour = BG_COLOUR, so all 64 pixels are written.

Test Plan:
- Reset, then idle 5 cycles -> char_ready = 1; plot = 0; done = 0; font_addr = 0.
- Request code 0x41, col 0, row 0, colour 3'b111; ROM row bytes 0x18 for all rows:
  - plot first in cycle E+3 at (0,0).
  - Cycles with x = 3, 4 have colour 7; other x have colour BG_COLOUR (plot = 0 there in the transparent build).
  - done in cycle E+81.
- Request col 19, row 14 -> pixels span x 152..159, y 112..119; font_addr sequence is {0x41, 0..7}, each presented for one FETCH cycle.
- Request col 20, row 3 -> no plot; done high in cycle E+1; char_ready high in cycle E+2.
- Assert resetn = 0 during row 4 of a character -> plot = 0 from the next cycle; no done pulse; next request is accepted and runs a full 81-cycle sequence.
- Two consecutive requests with char_valid held high -> second is accepted in the first IDLE cycle after done; char_valid pulses during DRAW are ignored.
